// File: rtl/ram_pkg.sv
// Shared constants and types for the 16x8 RAM, its FIFO controller and their benches.
package ram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    BufEmpty,
    BufOne,
    BufTwo
  } buf_state_e;

endpackage

// File: rtl/ram_out_skid.sv
// Two-entry output buffer that catches RAM read data and presents it as a ready/valid head.
module ram_out_skid
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [1:0]            cnt,
  output logic [DATA_WIDTH-1:0] head
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] second_q, second_d;

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    second_d = second_q;
    unique case (state_q)
      BufEmpty: begin
        if (push) begin
          head_d  = push_data;
          state_d = BufOne;
        end
      end
      BufOne: begin
        case ({push, pop})
          2'b10: begin
            second_d = push_data;
            state_d  = BufTwo;
          end
          2'b01:   state_d = BufEmpty;
          2'b11:   head_d  = push_data;
          default: ;
        endcase
      end
      BufTwo: begin
        if (pop) begin
          head_d = second_q;
          // Push alongside pop keeps the buffer full; the issue rule normally prevents it.
          if (push) second_d = push_data;
          else      state_d  = BufOne;
        end
      end
      default: state_d = BufEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BufEmpty;
      head_q   <= '0;
      second_q <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      second_q <= second_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(state_q == BufTwo && push && !pop))
        else $error("ram_out_skid: push into full output buffer");
    end
  end

  always_comb begin
    cnt = 2'd0;
    unique case (state_q)
      BufOne:  cnt = 2'd1;
      BufTwo:  cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
  end

  assign valid = (state_q != BufEmpty);
  assign head  = head_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller using a synchronous RAM as storage, with a 2-entry buffer hiding read latency.
module ram_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [ADDR_WIDTH:0] FullCnt = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0]   wp_q, rp_q, ram_cnt;
  logic                  rd_pend_q;
  logic                  pop;
  logic [1:0]            buf_cnt;
  logic [2:0]            occ;
  logic [ADDR_WIDTH+1:0] level_q, level_d;

  assign ram_cnt     = wp_q - rp_q;
  assign in_ready    = !rst && (ram_cnt != FullCnt);
  assign ram_wr_enb  = in_valid && in_ready;
  assign ram_wr_addr = wp_q[ADDR_WIDTH-1:0];
  assign ram_wr_data = in_data;

  assign pop = out_valid && out_ready;
  // Occupancy of the buffer counting the read still in flight; a pop this cycle frees a slot.
  assign occ         = {1'b0, buf_cnt} + {2'b00, rd_pend_q};
  assign ram_rd_enb  = !rst && (ram_cnt != '0) && (occ < (3'd2 + {2'b00, pop}));
  assign ram_rd_addr = rp_q[ADDR_WIDTH-1:0];

  // Every entry enters through a write and leaves through a pop, so track the total directly.
  assign level_d = level_q + (ADDR_WIDTH + 2)'(ram_wr_enb) - (ADDR_WIDTH + 2)'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      rd_pend_q <= 1'b0;
      level_q   <= '0;
    end else begin
      if (ram_wr_enb) wp_q <= wp_q + 1'b1;
      if (ram_rd_enb) rp_q <= rp_q + 1'b1;
      rd_pend_q <= ram_rd_enb;
      level_q   <= level_d;
    end
  end

  assign level = level_q;

  ram_out_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .push_data (ram_rd_data),
    .pop       (pop),
    .valid     (out_valid),
    .cnt       (buf_cnt),
    .head      (out_data)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 16x8 RAM, vector table and a scoreboard monitor.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [5:0] level;
  logic       ram_wr_enb;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       ram_rd_enb;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_rd_data;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .ADDR_WIDTH (4),
    .DEPTH      (16),
    .DATA_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .ram_wr_enb  (ram_wr_enb),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_enb  (ram_rd_enb),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // Behavioural RAM: one-cycle read latency, cleared by the same reset.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      ram_rd_data <= 8'h00;
    end else begin
      if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_enb) ram_rd_data <= mem[ram_rd_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor samples just before each rising edge.
  logic [7:0] sb [$];
  int cyc = 0;
  int acc_ph = 0, pop_ph = 0;
  int first_acc_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;

  always begin
    @(negedge clk);
    #4;
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        if (acc_ph == 0) first_acc_cyc = cyc;
        sb.push_back(in_data);
        acc_ph++;
      end
      if (out_valid && out_ready) begin
        if (pop_ph == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_ph++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_order: popped %0h, expected nothing queued", out_data);
        end else begin
          check("pop_order", {24'h0, out_data}, {24'h0, sb.pop_front()});
        end
      end
    end
  end

  task automatic wait_level_zero(input int max, input string name);
    int n = 0;
    while (level != 6'd0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, {26'h0, level}, 32'd0);
  endtask

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       irdy;
    logic       ov;
    logic [7:0] od;
    logic [5:0] lvl;
    logic       wen;
    logic       ren;
  } vec_t;

  vec_t vecs [14];

  initial begin
    //          rst   iv    id     ordy | irdy  ov    od     lvl   wen   ren
    vecs[0]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 6'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 6'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 6'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'hA5, 6'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'hA5, 6'd1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 6'd2, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 6'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 6'd1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h22, 6'd0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset, idle, single-beat latency and back-to-back beats.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("row%0d in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].irdy});
      check($sformatf("row%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ov});
      check($sformatf("row%0d out_data", i), {24'h0, out_data}, {24'h0, vecs[i].od});
      check($sformatf("row%0d level", i), {26'h0, level}, {26'h0, vecs[i].lvl});
      check($sformatf("row%0d ram_wr_enb", i), {31'h0, ram_wr_enb}, {31'h0, vecs[i].wen});
      check($sformatf("row%0d ram_rd_enb", i), {31'h0, ram_rd_enb}, {31'h0, vecs[i].ren});
    end

    // Fill to capacity with the output stalled, then drain in order.
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    acc_ph    = 0;
    pop_ph    = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (acc_ph >= 18) break;
      in_valid = 1'b1;
      in_data  = acc_ph[7:0];
    end
    in_data = 8'hEE;
    #1;
    check("full in_ready", {31'h0, in_ready}, 32'd0);
    check("full ram_wr_enb", {31'h0, ram_wr_enb}, 32'd0);
    check("full level", {26'h0, level}, 32'd18);
    repeat (3) @(negedge clk);
    check("full accepted", acc_ph, 32'd18);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_level_zero(80, "full drain level");
    check("full drained", pop_ph, 32'd18);

    // Sustained stream across two pointer wraps.
    @(negedge clk);
    acc_ph = 0;
    pop_ph = 0;
    for (int k = 0; k < 40; k++) begin
      in_valid = 1'b1;
      in_data  = k[7:0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_level_zero(20, "stream drain level");
    check("stream accepted", acc_ph, 32'd40);
    check("stream popped", pop_ph, 32'd40);
    check("stream fill latency", first_pop_cyc - first_acc_cyc, 32'd3);
    check("stream pop span", last_pop_cyc - first_pop_cyc, 32'd39);

    // Random handshakes against the scoreboard.
    @(negedge clk);
    acc_ph = 0;
    pop_ph = 0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (acc_ph >= 1000) break;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_level_zero(40, "random drain level");
    check("random accepted", acc_ph, 32'd1000);
    check("random popped", pop_ph, 32'd1000);
    check("random scoreboard empty", sb.size(), 32'd0);

    // Reset with entries queued and a read in flight.
    @(negedge clk);
    out_ready = 1'b0;
    acc_ph    = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (acc_ph >= 7) break;
      in_valid = 1'b1;
      in_data  = 8'h40 + acc_ph[7:0];
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("prerst level", {26'h0, level}, 32'd7);
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    #1;
    check("prerst ram_rd_enb", {31'h0, ram_rd_enb}, 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    in_data   = 8'h99;
    out_ready = 1'b0;
    #1;
    check("inrst level", {26'h0, level}, 32'd7);
    check("inrst ram_wr_enb", {31'h0, ram_wr_enb}, 32'd0);
    check("inrst ram_rd_enb", {31'h0, ram_rd_enb}, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("postrst out_valid", {31'h0, out_valid}, 32'd0);
    check("postrst level", {26'h0, level}, 32'd0);
    check("postrst out_data", {24'h0, out_data}, 32'd0);
    check("postrst in_ready", {31'h0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
    check("postrst first valid", {31'h0, out_valid}, 32'd1);
    check("postrst first data", {24'h0, out_data}, 32'h3C);
    wait_level_zero(10, "postrst drain level");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
